// File: rtl/rlc_game_system_key_edge_pio.sv
// Avalon-MM input PIO for push-button/switch banks: per-bit synchroniser,
// debounce filter, sticky edge capture (write-1-to-clear), interrupt mask
// and a level interrupt built from the masked capture register.
module rlc_game_system_key_edge_pio #(
    parameter int unsigned      WIDTH           = 3,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;

    logic [WIDTH-1:0] db_state_q, db_state_d, db_flip;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];

    logic [WIDTH-1:0] edge_q, edge_d, edge_set, edge_clr;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign wr_en        = chipselect & ~write_n;
    // Only the low WIDTH bits of writedata carry meaning.
    assign unused_wdata = ^writedata;

    // Synchroniser chain: stage 0 samples the raw pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_LEVEL;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Debounce: count consecutive disagreeing cycles, flip once the count saturates.
    always_comb begin
        db_flip = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_out[i] != db_state_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    db_flip[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
        db_state_d = db_state_q ^ db_flip;
    end

    // Edge qualification by direction of the accepted level change.
    always_comb begin
        edge_set = '0;
        case (EDGE_TYPE)
            0:       edge_set = db_flip & db_state_d;
            1:       edge_set = db_flip & ~db_state_d;
            default: edge_set = db_flip;
        endcase
    end

    // Register-file next state; a new edge beats a same-cycle W1C.
    always_comb begin
        edge_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        edge_d   = (edge_q & ~edge_clr) | edge_set;
        mask_d   = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
        case (address)
            2'd0:    readdata_d = 32'(db_state_q);
            2'd2:    readdata_d = 32'(mask_q);
            2'd3:    readdata_d = 32'(edge_q);
            default: readdata_d = '0;
        endcase
    end

    // Debounce, capture, mask and read-data state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_state_q <= RESET_LEVEL;
            edge_q     <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_state_q <= db_state_d;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_rlc_game_system_key_edge_pio.sv
// Bench for rlc_game_system_key_edge_pio (3 bits, 2 sync stages, 4-cycle
// debounce, falling-edge capture, keys idle high).
module tb_rlc_game_system_key_edge_pio;

    localparam int          SYNC = 2;
    localparam int          DB   = 4;
    localparam int          H    = SYNC + DB;
    localparam logic [2:0]  RL   = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [2:0]  in_port = RL;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    rlc_game_system_key_edge_pio #(
        .WIDTH          (3),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .EDGE_TYPE      (1),
        .RESET_LEVEL    (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last DB synchronised
    // samples (pins seen SYNC edges ago) all disagree with the accepted level.
    logic [2:0]  m_db, m_edge, m_mask, m_flip, m_clr;
    logic [31:0] m_rd;
    logic [2:0]  m_hist [H];
    logic        m_wr, m_irq;

    function automatic logic [2:0] window_flip(input logic [2:0] db, input logic [2:0] h [H]);
        logic [2:0] f;
        f = 3'b111;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < DB; k++) begin
                if (h[H-SYNC-k][i] == db[i]) f[i] = 1'b0;
            end
        end
        return f;
    endfunction

    always_comb m_flip = window_flip(m_db, m_hist);
    assign m_wr  = chipselect && !write_n;
    assign m_clr = (m_wr && address == 2'd3) ? writedata[2:0] : 3'b000;
    assign m_irq = |(m_edge & m_mask);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_db   <= RL;
            m_edge <= 3'b000;
            m_mask <= 3'b000;
            m_rd   <= 32'd0;
            for (int k = 0; k < H; k++) m_hist[k] <= RL;
        end else begin
            m_db   <= m_db ^ m_flip;
            // falling capture: a bit that was high and is accepted low
            m_edge <= (m_edge & ~m_clr) | (m_flip & m_db);
            if (m_wr && address == 2'd2) m_mask <= writedata[2:0];
            m_rd   <= (address == 2'd0) ? {29'd0, m_db} :
                      (address == 2'd2) ? {29'd0, m_mask} :
                      (address == 2'd3) ? {29'd0, m_edge} : 32'd0;
            for (int k = 0; k < H - 1; k++) m_hist[k] <= m_hist[k+1];
            m_hist[H-1] <= in_port;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        n_checks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: readdata=%0h irq=%0b want 0 0", readdata, irq);
        end
        reset   = 1'b0;
        address = 2'd0;
        tick(1);
        n_checks++;
        if (readdata !== 32'd7) begin
            n_fail++;
            $display("FAIL reset_db: got %0h want 7", readdata);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %0b want 0", irq);
        end
        address = 2'd2;
        n_checks++;
        if (readdata !== 32'd7) begin
            n_fail++;
            $display("FAIL read_latency: got %0h want 7 before edge", readdata);
        end
        tick(1);
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mask: got %0h want 0", readdata);
        end
        address = 2'd3;
        tick(1);
        n_checks++;
        if (readdata !== 32'd0 || readdata !== m_rd) begin
            n_fail++;
            $display("FAIL reset_edge: got %0h want 0 (model %0h)", readdata, m_rd);
        end
    endtask

    task automatic test_edge_capture();
        address    = 2'd0;
        in_port[0] = 1'b0;
        tick(SYNC + DB);
        n_checks++;
        if (readdata !== 32'd7) begin
            n_fail++;
            $display("FAIL db_early: got %0h want 7", readdata);
        end
        tick(1);
        n_checks++;
        if (readdata !== 32'd6) begin
            n_fail++;
            $display("FAIL db_fall: got %0h want 6", readdata);
        end
        address = 2'd3;
        tick(1);
        n_checks++;
        if (readdata !== 32'd1) begin
            n_fail++;
            $display("FAIL edge_bit0: got %0h want 1", readdata);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_masked: got %0b want 0", irq);
        end
    endtask

    task automatic test_glitch();
        address    = 2'd0;
        in_port[1] = 1'b0;
        tick(DB - 1);
        in_port[1] = 1'b1;
        tick(8);
        n_checks++;
        if (readdata !== 32'd6) begin
            n_fail++;
            $display("FAIL glitch_db: got %0h want 6", readdata);
        end
        address = 2'd3;
        tick(1);
        n_checks++;
        if (readdata !== 32'd1) begin
            n_fail++;
            $display("FAIL glitch_edge: got %0h want 1", readdata);
        end
        address    = 2'd0;
        in_port[1] = 1'b0;
        tick(DB);
        in_port[1] = 1'b1;
        tick(3);
        n_checks++;
        if (readdata !== 32'd4) begin
            n_fail++;
            $display("FAIL pulse4_db: got %0h want 4", readdata);
        end
        tick(6);
        n_checks++;
        if (readdata !== 32'd6) begin
            n_fail++;
            $display("FAIL pulse4_recover: got %0h want 6", readdata);
        end
        address = 2'd3;
        tick(1);
        n_checks++;
        if (readdata !== 32'd3 || readdata !== m_rd) begin
            n_fail++;
            $display("FAIL pulse4_edge: got %0h want 3 (model %0h)", readdata, m_rd);
        end
    endtask

    task automatic test_irq();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_pre_mask: got %0b want 0", irq);
        end
        wr(2'd2, 32'd1);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_unmask: got %0b want 1", irq);
        end
        wr(2'd3, 32'd7);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_w1c: got %0b want 0", irq);
        end
        address = 2'd3;
        tick(1);
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL edge_cleared: got %0h want 0", readdata);
        end
    endtask

    task automatic test_back_to_back();
        in_port[2] = 1'b0;
        tick(SYNC + DB - 1);
        address    = 2'd3;
        writedata  = 32'd4;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick(1);
        n_checks++;
        if (readdata !== 32'd4) begin
            n_fail++;
            $display("FAIL set_beats_clear: got %0h want 4", readdata);
        end
        wr(2'd3, 32'd7);
        in_port = 3'b111;
        tick(10);
        address = 2'd3;
        tick(1);
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rise_no_capture: got %0h want 0", readdata);
        end
        address = 2'd0;
        tick(1);
        n_checks++;
        if (readdata !== 32'd7) begin
            n_fail++;
            $display("FAIL rise_db: got %0h want 7", readdata);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            in_port = 3'($urandom);
            repeat ($urandom_range(1, 7)) begin
                if ($urandom_range(0, 3) == 0) begin
                    chipselect = 1'b1;
                    write_n    = 1'b0;
                end else begin
                    chipselect = 1'($urandom_range(0, 1));
                    write_n    = 1'b1;
                end
                address   = 2'($urandom);
                writedata = $urandom;
                tick(1);
                n_checks++;
                if (readdata !== m_rd) begin
                    n_fail++;
                    $display("FAIL rand_read: got %0h want %0h", readdata, m_rd);
                end
                n_checks++;
                if (irq !== m_irq) begin
                    n_fail++;
                    $display("FAIL rand_irq: got %0b want %0b", irq, m_irq);
                end
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_mid_reset();
        wr(2'd3, 32'd7);
        in_port = 3'b111;
        tick(10);
        wr(2'd2, 32'd7);
        in_port = 3'b110;
        tick(10);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_irq: got %0b want 1", irq);
        end
        in_port = 3'b010;
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (irq !== 1'b0 || readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: irq=%0b readdata=%0h want 0 0", irq, readdata);
        end
        tick(2);
        reset   = 1'b0;
        address = 2'd3;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            n_checks++;
            if (irq !== 1'b0 || readdata !== 32'd0) begin
                n_fail++;
                $display("FAIL post_release: cycle %0d irq=%0b readdata=%0h want 0 0",
                         c, irq, readdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge_capture();
        test_glitch();
        test_irq();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
